// File: rtl/eprisc_mem_tester_pkg.sv
// Shared types and helpers for the eprisc memory test engine.
// Holds the FSM state encoding, default seed, error-counter width and pattern function.
package eprisc_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [31:0] SEED_DEFAULT = 32'h24413345;
    localparam int          ERR_W        = 16;
    localparam int          PAT_W        = 64;

    // Callers pass a zero-extended seed and address and keep the low DATA_WIDTH bits.
    function automatic logic [PAT_W-1:0] pattern_word(
        input logic [PAT_W-1:0] seed,
        input logic [PAT_W-1:0] addr,
        input logic             invert
    );
        logic [PAT_W-1:0] p;
        p = seed ^ addr;
        return invert ? ~p : p;
    endfunction

endpackage

// File: rtl/eprisc_mem_tester_if.sv
// Single-port synchronous-read memory bus, driven by the tester from the master side.
interface eprisc_mem_tester_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] oAddr;
    logic                  oWrite;
    logic [DATA_WIDTH-1:0] oData;
    logic [DATA_WIDTH-1:0] iData;

    modport master (
        output oAddr,
        output oWrite,
        output oData,
        input  iData
    );

    modport slave (
        input  oAddr,
        input  oWrite,
        input  oData,
        output iData
    );
endinterface

// File: rtl/eprisc_mem_tester_checker.sv
// Read-back compare stage: one-deep expected/address register, first-fail capture
// and a saturating mismatch counter.
module eprisc_mem_checker
    import eprisc_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  check_valid,
    input  logic [DATA_WIDTH-1:0] check_exp,
    input  logic [ADDR_WIDTH-1:0] check_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_got,
    output logic [ERR_W-1:0]      err_count,
    output logic [ERR_W-1:0]      err_count_next
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    logic                  cmp_valid_q, cmp_valid_d;
    logic [DATA_WIDTH-1:0] cmp_exp_q,   cmp_exp_d;
    logic [ADDR_WIDTH-1:0] cmp_addr_q,  cmp_addr_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_exp_q,  fail_exp_d;
    logic [DATA_WIDTH-1:0] fail_got_q,  fail_got_d;
    logic [ERR_W-1:0]      err_q,       err_d;
    logic                  mismatch;

    // The counter never returns to zero once it has counted, so zero means "no failure seen yet".
    always_comb begin
        mismatch    = cmp_valid_q && (rd_data != cmp_exp_q);
        cmp_valid_d = check_valid;
        cmp_exp_d   = check_exp;
        cmp_addr_d  = check_addr;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        err_d       = err_q;

        if (clear) begin
            cmp_valid_d = 1'b0;
            fail_addr_d = '0;
            fail_exp_d  = '0;
            fail_got_d  = '0;
            err_d       = '0;
        end else if (mismatch) begin
            if (err_q == '0) begin
                fail_addr_d = cmp_addr_q;
                fail_exp_d  = cmp_exp_q;
                fail_got_d  = rd_data;
            end
            if (err_q != ERR_MAX) begin
                err_d = err_q + ERR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_valid_q <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
            err_q       <= '0;
        end else begin
            cmp_valid_q <= cmp_valid_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
            err_q       <= err_d;
        end
    end

    assign fail_addr      = fail_addr_q;
    assign fail_exp       = fail_exp_q;
    assign fail_got       = fail_got_q;
    assign err_count      = err_q;
    assign err_count_next = err_d;

endmodule

// File: rtl/eprisc_mem_tester.sv
// Memory test engine: writes a seed^address pattern over a window, reads it back and
// compares, then repeats with the inverted pattern and reports pass/fail status.
module eprisc_mem_tester
    import eprisc_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] SEED       = SEED_DEFAULT
) (
    input  logic                  iClk,
    input  logic                  iReset_n,
    input  logic                  iStart,
    input  logic [ADDR_WIDTH-1:0] iBase,
    input  logic [ADDR_WIDTH:0]   iCount,
    eprisc_mem_tester_if.master   mem,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oPass,
    output logic [ADDR_WIDTH-1:0] oFailAddr,
    output logic [DATA_WIDTH-1:0] oFailExp,
    output logic [DATA_WIDTH-1:0] oFailGot,
    output logic [ERR_W-1:0]      oErrCount
);

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   IDX_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [DATA_WIDTH-1:0] pat(
        input logic [ADDR_WIDTH-1:0] a,
        input logic                  inv
    );
        logic [PAT_W-1:0] full;
        full = pattern_word(PAT_W'(SEED), PAT_W'(a), inv);
        return full[DATA_WIDTH-1:0];
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [ADDR_WIDTH-1:0] base_q,  base_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   idx_q,   idx_d;
    logic                  phase_q, phase_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;
    logic                  pass_q,  pass_d;

    logic                  start_ok;
    logic                  last_idx;
    logic [ADDR_WIDTH:0]   count_clamped;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  check_valid;
    logic [DATA_WIDTH-1:0] check_exp;
    logic [ERR_W-1:0]      err_next;

    assign start_ok      = iStart && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign count_clamped = (iCount > FULL_COUNT) ? FULL_COUNT : iCount;
    assign last_idx      = (idx_q == (count_q - IDX_ONE));
    assign next_addr     = addr_q + ADDR_ONE;
    assign check_valid   = (state_q == S_READ);
    assign check_exp     = pat(addr_q, phase_q);

    // Address register simply increments, so the window wraps modulo 2^ADDR_WIDTH by itself.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        data_d  = data_q;
        base_d  = base_q;
        count_d = count_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    base_d  = iBase;
                    count_d = count_clamped;
                    idx_d   = '0;
                    phase_d = 1'b0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    if (count_clamped == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_WRITE;
                        busy_d  = 1'b1;
                        addr_d  = iBase;
                        write_d = 1'b1;
                        data_d  = pat(iBase, 1'b0);
                    end
                end
            end
            S_WRITE: begin
                if (last_idx) begin
                    state_d = S_READ;
                    idx_d   = '0;
                    addr_d  = base_q;
                    write_d = 1'b0;
                end else begin
                    idx_d  = idx_q + IDX_ONE;
                    addr_d = next_addr;
                    data_d = pat(next_addr, phase_q);
                end
            end
            S_READ: begin
                if (last_idx) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d  = idx_q + IDX_ONE;
                    addr_d = next_addr;
                end
            end
            S_DRAIN: begin
                if (!phase_q) begin
                    state_d = S_WRITE;
                    phase_d = 1'b1;
                    idx_d   = '0;
                    addr_d  = base_q;
                    write_d = 1'b1;
                    data_d  = pat(base_q, 1'b1);
                end else begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_next == '0);
                end
            end
            default: begin
                state_d = S_IDLE;
                write_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            data_q  <= '0;
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            data_q  <= data_d;
            base_q  <= base_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    eprisc_mem_checker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_checker (
        .clk            (iClk),
        .rst_n          (iReset_n),
        .clear          (start_ok),
        .check_valid    (check_valid),
        .check_exp      (check_exp),
        .check_addr     (addr_q),
        .rd_data        (mem.iData),
        .fail_addr      (oFailAddr),
        .fail_exp       (oFailExp),
        .fail_got       (oFailGot),
        .err_count      (oErrCount),
        .err_count_next (err_next)
    );

    assign mem.oAddr  = addr_q;
    assign mem.oWrite = write_q;
    assign mem.oData  = data_q;
    assign oBusy      = busy_q;
    assign oDone      = done_q;
    assign oPass      = pass_q;

endmodule

// File: tb/tb_eprisc_mem_tester.sv
// Directed self-checking bench for eprisc_mem_tester with a 4096-word synchronous RAM
// model that can inject a stuck bit or force all reads to zero.
module tb_eprisc_mem_tester;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   count;
    logic          busy, done, pass;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_exp, fail_got;
    logic [15:0]   err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eprisc_mem_tester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    eprisc_mem_tester dut (
        .iClk      (clk),
        .iReset_n  (rst_n),
        .iStart    (start),
        .iBase     (base),
        .iCount    (count),
        .mem       (bus),
        .oBusy     (busy),
        .oDone     (done),
        .oPass     (pass),
        .oFailAddr (fail_addr),
        .oFailExp  (fail_exp),
        .oFailGot  (fail_got),
        .oErrCount (err_count)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            stuck_en;
    bit            zero_reads;
    int            busy_cycles = 0;
    logic [AW-1:0] wr_addr_log [$];
    logic [DW-1:0] wr_data_log [$];

    // RAM model with one-cycle read latency plus an access log used by the tests.
    always @(posedge clk) begin
        if (bus.oWrite) begin
            mem[bus.oAddr] <= bus.oData;
            wr_addr_log.push_back(bus.oAddr);
            wr_data_log.push_back(bus.oData);
        end
        if (zero_reads)
            bus.iData <= '0;
        else if (stuck_en && bus.oAddr == 12'd5)
            bus.iData <= mem[bus.oAddr] & ~32'd1;
        else
            bus.iData <= mem[bus.oAddr];
        if (busy)
            busy_cycles <= busy_cycles + 1;
    end

    task automatic start_test(input logic [AW-1:0] b, input logic [AW:0] n);
        @(negedge clk);
        base  = b;
        count = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < limit; i++) begin
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        base  = '0;
        count = '0;
        #23;
        checks++;
        if ({bus.oAddr, bus.oWrite, bus.oData} !== 45'd0) begin
            errors++;
            $display("[TB] FAIL reset_bus: got %h expected 0", {bus.oAddr, bus.oWrite, bus.oData});
        end
        checks++;
        if ({busy, done, pass} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_status: got %b expected 000", {busy, done, pass});
        end
        checks++;
        if ({fail_addr, fail_exp, fail_got, err_count} !== 92'd0) begin
            errors++;
            $display("[TB] FAIL reset_fail_regs: got %h expected 0", {fail_addr, fail_exp, fail_got, err_count});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_pass;
        int b0, w0;
        bit to;
        b0 = busy_cycles;
        w0 = wr_addr_log.size();
        start_test(12'h000, 13'd16);
        checks++;
        if ({busy, done, bus.oWrite, bus.oAddr, bus.oData} !== {1'b1, 1'b0, 1'b1, 12'h000, 32'h24413345}) begin
            errors++;
            $display("[TB] FAIL clean_first_write: got %h expected %h", {busy, done, bus.oWrite, bus.oAddr, bus.oData},
                     {1'b1, 1'b0, 1'b1, 12'h000, 32'h24413345});
        end
        wait_done(200, to);
        checks++;
        if (to) begin
            errors++;
            $display("[TB] FAIL clean_timeout: got no done expected done within 200 cycles");
        end
        checks++;
        if ({done, busy, pass, err_count} !== {3'b101, 16'd0}) begin
            errors++;
            $display("[TB] FAIL clean_result: got done/busy/pass/err %b%b%b/%0d expected 101/0", done, busy, pass, err_count);
        end
        checks++;
        if (busy_cycles - b0 !== 66) begin
            errors++;
            $display("[TB] FAIL clean_busy_cycles: got %0d expected 66", busy_cycles - b0);
        end
        checks++;
        if (wr_addr_log.size() - w0 !== 32) begin
            errors++;
            $display("[TB] FAIL clean_write_count: got %0d expected 32", wr_addr_log.size() - w0);
        end
        checks++;
        if ({wr_data_log[w0+5], wr_data_log[w0+16]} !== {32'h24413340, 32'hDBBECCBA}) begin
            errors++;
            $display("[TB] FAIL clean_pattern: got %h %h expected 24413340 dbbeccba", wr_data_log[w0+5], wr_data_log[w0+16]);
        end
    endtask

    task automatic test_stuck_bit;
        bit to;
        stuck_en = 1'b1;
        start_test(12'h000, 13'd16);
        checks++;
        if ({done, pass} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL stuck_start_clears: got done/pass %b%b expected 00", done, pass);
        end
        wait_done(200, to);
        stuck_en = 1'b0;
        checks++;
        if (to) begin
            errors++;
            $display("[TB] FAIL stuck_timeout: got no done expected done within 200 cycles");
        end
        checks++;
        if ({pass, err_count, fail_addr} !== {1'b0, 16'd1, 12'h005}) begin
            errors++;
            $display("[TB] FAIL stuck_result: got pass/err/addr %b/%0d/%h expected 0/1/005", pass, err_count, fail_addr);
        end
        checks++;
        if ({fail_exp, fail_got} !== {32'hDBBECCBF, 32'hDBBECCBE}) begin
            errors++;
            $display("[TB] FAIL stuck_fail_data: got exp/got %h/%h expected dbbeccbf/dbbeccbe", fail_exp, fail_got);
        end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] exp_seq [8] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'hFFE, 12'hFFF, 12'h000, 12'h001};
        int b0, w0;
        bit to;
        b0 = busy_cycles;
        w0 = wr_addr_log.size();
        start_test(12'hFFE, 13'd4);
        checks++;
        if ({err_count, fail_addr, bus.oAddr, bus.oData} !== {16'd0, 12'h000, 12'hFFE, 32'h24413CBB}) begin
            errors++;
            $display("[TB] FAIL wrap_start: got err/faddr/addr/data %0d/%h/%h/%h expected 0/000/ffe/24413cbb",
                     err_count, fail_addr, bus.oAddr, bus.oData);
        end
        wait_done(100, to);
        checks++;
        if (to || pass !== 1'b1 || err_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL wrap_result: got timeout/pass/err %b/%b/%0d expected 0/1/0", to, pass, err_count);
        end
        checks++;
        if (wr_addr_log.size() - w0 !== 8 || busy_cycles - b0 !== 18) begin
            errors++;
            $display("[TB] FAIL wrap_counts: got writes/busy %0d/%0d expected 8/18", wr_addr_log.size() - w0, busy_cycles - b0);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (wr_addr_log[w0+i] !== exp_seq[i]) begin
                errors++;
                $display("[TB] FAIL wrap_addr_%0d: got %h expected %h", i, wr_addr_log[w0+i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_empty;
        int b0, w0;
        b0 = busy_cycles;
        w0 = wr_addr_log.size();
        start_test(12'h123, 13'd0);
        checks++;
        if ({done, pass, busy, bus.oWrite} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL empty_result: got done/pass/busy/wr %b expected 1100", {done, pass, busy, bus.oWrite});
        end
        repeat (5) @(negedge clk);
        checks++;
        if (wr_addr_log.size() - w0 !== 0 || busy_cycles - b0 !== 0) begin
            errors++;
            $display("[TB] FAIL empty_activity: got writes/busy %0d/%0d expected 0/0", wr_addr_log.size() - w0, busy_cycles - b0);
        end
    endtask

    task automatic test_reset_mid;
        int b0;
        bit to;
        start_test(12'h040, 13'd16);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.oWrite, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_mid_write: got wr/busy %b expected 00", {bus.oWrite, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_test(12'h040, 13'd16);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.oWrite, busy, done, err_count} !== 19'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_read: got wr/busy/done/err %b%b%b/%0d expected 000/0", bus.oWrite, busy, done, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        b0 = busy_cycles;
        start_test(12'h200, 13'd8);
        wait_done(100, to);
        checks++;
        if (to || {pass, err_count} !== {1'b1, 16'd0} || busy_cycles - b0 !== 34) begin
            errors++;
            $display("[TB] FAIL reset_restart: got timeout/pass/err/busy %b/%b/%0d/%0d expected 0/1/0/34",
                     to, pass, err_count, busy_cycles - b0);
        end
    endtask

    task automatic test_back_to_back;
        int b0, w0;
        bit to;
        b0 = busy_cycles;
        w0 = wr_addr_log.size();
        start_test(12'h100, 13'd4);
        base  = 12'h200;
        count = 13'd16;
        start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        wait_done(100, to);
        checks++;
        if (to || wr_addr_log.size() - w0 !== 8 || busy_cycles - b0 !== 18) begin
            errors++;
            $display("[TB] FAIL busy_start_ignored: got timeout/writes/busy %b/%0d/%0d expected 0/8/18",
                     to, wr_addr_log.size() - w0, busy_cycles - b0);
        end
        checks++;
        if ({wr_addr_log[w0], wr_addr_log[w0+3]} !== {12'h100, 12'h103}) begin
            errors++;
            $display("[TB] FAIL busy_start_addr: got %h %h expected 100 103", wr_addr_log[w0], wr_addr_log[w0+3]);
        end
        b0 = busy_cycles;
        start_test(12'h300, 13'd1);
        checks++;
        if ({busy, done, bus.oAddr} !== {2'b10, 12'h300}) begin
            errors++;
            $display("[TB] FAIL restart_from_done: got busy/done/addr %b%b/%h expected 10/300", busy, done, bus.oAddr);
        end
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({done, busy, pass} !== 3'b101 || busy_cycles - b0 !== 6) begin
            errors++;
            $display("[TB] FAIL start_at_done_edge: got done/busy/pass %b busy %0d expected 101 busy 6",
                     {done, busy, pass}, busy_cycles - b0);
        end
    endtask

    task automatic test_all_zero;
        bit to;
        zero_reads = 1'b1;
        start_test(12'h000, 13'h1000);
        wait_done(20000, to);
        zero_reads = 1'b0;
        checks++;
        if (to || {pass, err_count, fail_addr} !== {1'b0, 16'd8192, 12'h000}) begin
            errors++;
            $display("[TB] FAIL zero_result: got timeout/pass/err/addr %b/%b/%0d/%h expected 0/0/8192/000",
                     to, pass, err_count, fail_addr);
        end
        checks++;
        if ({fail_exp, fail_got} !== {32'h24413345, 32'h00000000}) begin
            errors++;
            $display("[TB] FAIL zero_fail_data: got exp/got %h/%h expected 24413345/00000000", fail_exp, fail_got);
        end
    endtask

    task automatic test_clamp;
        int b0, w0;
        bit to;
        b0 = busy_cycles;
        w0 = wr_addr_log.size();
        start_test(12'h800, 13'h1FFF);
        wait_done(20000, to);
        checks++;
        if (to || {pass, err_count} !== {1'b1, 16'd0} || busy_cycles - b0 !== 16386 || wr_addr_log.size() - w0 !== 8192) begin
            errors++;
            $display("[TB] FAIL clamp_result: got timeout/pass/err/busy/writes %b/%b/%0d/%0d/%0d expected 0/1/0/16386/8192",
                     to, pass, err_count, busy_cycles - b0, wr_addr_log.size() - w0);
        end
    endtask

    initial begin
        test_reset();
        test_clean_pass();
        test_stuck_bit();
        test_wrap();
        test_empty();
        test_reset_mid();
        test_back_to_back();
        test_all_zero();
        test_clamp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
